// File: rtl/twos_comp_seq_if.sv
// Operand/result handshake bundle for twos_comp_seq: operand side, result side, phase pulses.
// The master drives the operand and out_ready; the slave (the complementer) drives everything else.
interface twos_comp_seq_if #(
  parameter int N_BITS = 8
);
  localparam int PULSES = N_BITS + 1;

  logic [N_BITS-1:0] B;
  logic [1:0]        mode;
  logic              in_valid;
  logic              in_ready;
  logic [N_BITS-1:0] Bbar;
  logic              ovf;
  logic              out_valid;
  logic              out_ready;
  logic [PULSES-1:0] T;
  logic              busy;

  modport master (
    output B, mode, in_valid, out_ready,
    input  in_ready, Bbar, ovf, out_valid, T, busy
  );

  modport slave (
    input  B, mode, in_valid, out_ready,
    output in_ready, Bbar, ovf, out_valid, T, busy
  );
endinterface

// File: rtl/twos_comp_seq.sv
// Bit-serial ones/twos/pass/abs complementer, LSB first; result N_BITS+1 edges after accept.
// One operand per IDLE visit; the result is held in DONE until out_ready, and in_ready is low meanwhile.
module twos_comp_seq #(
  parameter int N_BITS = 8
) (
  input logic            clk,
  input logic            rst,
  twos_comp_seq_if.slave bus
);
  localparam int PULSES = N_BITS + 1;
  localparam int IW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_BITS - 1);
  localparam logic [1:0] M_ONES = 2'd0;
  localparam logic [1:0] M_TWOS = 2'd1;
  localparam logic [1:0] M_PASS = 2'd2;
  localparam logic [1:0] M_ABS  = 2'd3;

  typedef enum logic [1:0] {IDLE, CLEAR, PROC, DONE} state_t;

  state_t            state;
  logic [N_BITS-1:0] op;
  logic [N_BITS-1:0] res;
  logic [1:0]        eff;
  logic              seen;
  logic [IW-1:0]     idx;
  logic [PULSES-1:0] t;
  logic              in_rdy;
  logic              out_vld;
  logic              ovf_q;
  logic              busy_q;
  logic              bit_b;
  logic              bit_r;

  always_comb begin
    bit_b = op[idx];
    bit_r = bit_b;
    case (eff)
      M_ONES:  bit_r = ~bit_b;
      M_TWOS:  bit_r = seen ? ~bit_b : bit_b;
      default: bit_r = bit_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op      <= '0;
      res     <= '0;
      eff     <= M_PASS;
      seen    <= 1'b0;
      idx     <= '0;
      t       <= '0;
      in_rdy  <= 1'b1;
      out_vld <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_rdy) begin
            op <= bus.B;
            // abs collapses to twos or pass here so PROC only sees three modes
            if (bus.mode == M_ABS)
              eff <= bus.B[N_BITS-1] ? M_TWOS : M_PASS;
            else
              eff <= bus.mode;
            state  <= CLEAR;
            t      <= PULSES'(1);
            in_rdy <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          res   <= '0;
          seen  <= 1'b0;
          idx   <= '0;
          ovf_q <= 1'b0;
          t     <= PULSES'(2);
          state <= PROC;
        end
        PROC: begin
          res[idx] <= bit_r;
          if (bit_b) seen <= 1'b1;
          if (idx == LAST) begin
            state   <= DONE;
            t       <= '0;
            busy_q  <= 1'b0;
            out_vld <= 1'b1;
            // only the most-negative operand keeps its MSB set after negation
            ovf_q   <= (eff == M_TWOS) && op[N_BITS-1] && bit_r;
          end else begin
            idx <= idx + 1'b1;
            t   <= t << 1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state   <= IDLE;
            out_vld <= 1'b0;
            in_rdy  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.Bbar      = res;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_vld;
  assign bus.T         = t;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_twos_comp_seq.sv
// Directed bench for twos_comp_seq at N_BITS=8, 2 and 16 with a small arithmetic reference model.
module tb_twos_comp_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  twos_comp_seq_if #(.N_BITS(8))  i8 ();
  twos_comp_seq_if #(.N_BITS(2))  i2 ();
  twos_comp_seq_if #(.N_BITS(16)) i16 ();

  twos_comp_seq #(.N_BITS(8))  dut8  (.clk(clk), .rst(rst), .bus(i8));
  twos_comp_seq #(.N_BITS(2))  dut2  (.clk(clk), .rst(rst), .bus(i2));
  twos_comp_seq #(.N_BITS(16)) dut16 (.clk(clk), .rst(rst), .bus(i16));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {ovf, result} from plain arithmetic, independent of the serial algorithm.
  function automatic logic [8:0] model8(input logic [7:0] b, input logic [1:0] m);
    logic [7:0] neg;
    neg = 8'(8'd0 - b);
    case (m)
      2'd0:    return {1'b0, ~b};
      2'd1:    return {(b == 8'h80), neg};
      2'd2:    return {1'b0, b};
      default: return b[7] ? {(b == 8'h80), neg} : {1'b0, b};
    endcase
  endfunction

  task automatic run8(input logic [7:0] b, input logic [1:0] m,
                      output logic [7:0] r, output logic o, output int lat);
    i8.B = b;
    i8.mode = m;
    i8.in_valid = 1'b1;
    tick;
    i8.in_valid = 1'b0;
    i8.B = ~b;
    i8.mode = ~m;
    lat = 0;
    while (!i8.out_valid && lat < 40) begin
      tick;
      lat++;
    end
    r = i8.Bbar;
    o = i8.ovf;
    if (i8.out_ready) tick;
  endtask

  initial begin
    logic [7:0] r;
    logic       o;
    int         lat;
    logic [8:0] exp9;
    logic [7:0] rb;
    logic [1:0] rm;

    i8.B = '0;  i8.mode = '0;  i8.in_valid = 1'b0;  i8.out_ready = 1'b1;
    i2.B = '0;  i2.mode = '0;  i2.in_valid = 1'b0;  i2.out_ready = 1'b1;
    i16.B = '0; i16.mode = '0; i16.in_valid = 1'b0; i16.out_ready = 1'b1;

    // Reset state
    tick;
    tick;
    chk("rst_in_ready", i8.in_ready, 1);
    chk("rst_out_valid", i8.out_valid, 0);
    chk("rst_Bbar", i8.Bbar, 0);
    chk("rst_ovf", i8.ovf, 0);
    chk("rst_T", i8.T, 0);
    chk("rst_busy", i8.busy, 0);
    rst = 1'b0;
    tick;

    // Pulse sequence and first-result latency: twos of 0x05
    i8.B = 8'h05;
    i8.mode = 2'd1;
    i8.in_valid = 1'b1;
    tick;
    i8.in_valid = 1'b0;
    i8.B = 8'hC3;
    chk("t1_T_clear", i8.T, 32'h1);
    chk("t1_busy", i8.busy, 1);
    chk("t1_in_ready_low", i8.in_ready, 0);
    for (int k = 1; k <= 8; k++) begin
      tick;
      chk("t1_T_step", i8.T, 32'(1) << k);
      chk("t1_no_early_valid", i8.out_valid, 0);
    end
    tick;
    chk("t1_out_valid", i8.out_valid, 1);
    chk("t1_T_done", i8.T, 0);
    chk("t1_busy_done", i8.busy, 0);
    chk("t1_Bbar", i8.Bbar, 32'hFB);
    chk("t1_ovf", i8.ovf, 0);
    tick;
    chk("t1_back_idle", i8.in_ready, 1);

    // Mode coverage
    run8(8'h5A, 2'd0, r, o, lat); chk("ones_5A", {o, r}, {1'b0, 8'hA5});
    chk("ones_lat", lat, 9);
    run8(8'h5A, 2'd2, r, o, lat); chk("pass_5A", {o, r}, {1'b0, 8'h5A});
    run8(8'hFE, 2'd3, r, o, lat); chk("abs_FE", {o, r}, {1'b0, 8'h02});
    run8(8'h12, 2'd3, r, o, lat); chk("abs_12", {o, r}, {1'b0, 8'h12});

    // Twos boundaries
    run8(8'h00, 2'd1, r, o, lat); chk("twos_00", {o, r}, {1'b0, 8'h00});
    run8(8'h80, 2'd1, r, o, lat); chk("twos_80", {o, r}, {1'b1, 8'h80});
    run8(8'hFF, 2'd1, r, o, lat); chk("twos_FF", {o, r}, {1'b0, 8'h01});
    run8(8'h7F, 2'd1, r, o, lat); chk("twos_7F", {o, r}, {1'b0, 8'h81});
    run8(8'h80, 2'd3, r, o, lat); chk("abs_80", {o, r}, {1'b1, 8'h80});

    // Backpressure in DONE
    i8.out_ready = 1'b0;
    run8(8'h5A, 2'd0, r, o, lat);
    chk("bp_first", {o, r}, {1'b0, 8'hA5});
    for (int i = 0; i < 5; i++) begin
      i8.B = 8'($urandom);
      i8.mode = 2'($urandom);
      i8.in_valid = i[0];
      tick;
      chk("bp_Bbar", i8.Bbar, 32'hA5);
      chk("bp_ovf", i8.ovf, 0);
      chk("bp_out_valid", i8.out_valid, 1);
      chk("bp_in_ready", i8.in_ready, 0);
    end
    i8.in_valid = 1'b0;
    i8.out_ready = 1'b1;
    tick;
    chk("bp_release_valid", i8.out_valid, 0);
    chk("bp_release_ready", i8.in_ready, 1);
    run8(8'h03, 2'd1, r, o, lat); chk("bp_next", {o, r}, {1'b0, 8'hFD});
    chk("bp_next_lat", lat, 9);

    // Reset in the middle of PROC at idx=3
    i8.B = 8'hA7;
    i8.mode = 2'd1;
    i8.in_valid = 1'b1;
    tick;
    i8.in_valid = 1'b0;
    repeat (4) tick;
    chk("mid_T_idx3", i8.T, 32'h10);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_in_ready", i8.in_ready, 1);
    chk("mid_out_valid", i8.out_valid, 0);
    chk("mid_Bbar", i8.Bbar, 0);
    chk("mid_ovf", i8.ovf, 0);
    chk("mid_T", i8.T, 0);
    chk("mid_busy", i8.busy, 0);
    run8(8'h01, 2'd1, r, o, lat); chk("mid_after", {o, r}, {1'b0, 8'hFF});
    chk("mid_after_lat", lat, 9);

    // N_BITS=2
    i2.B = 2'b10;
    i2.mode = 2'd1;
    i2.in_valid = 1'b1;
    tick;
    i2.in_valid = 1'b0;
    lat = 0;
    while (!i2.out_valid && lat < 40) begin tick; lat++; end
    chk("n2_Bbar", i2.Bbar, 32'h2);
    chk("n2_ovf", i2.ovf, 1);
    chk("n2_lat", lat, 3);
    tick;

    // N_BITS=16
    i16.B = 16'h0001;
    i16.mode = 2'd1;
    i16.in_valid = 1'b1;
    tick;
    i16.in_valid = 1'b0;
    lat = 0;
    while (!i16.out_valid && lat < 40) begin tick; lat++; end
    chk("n16_Bbar", i16.Bbar, 32'hFFFF);
    chk("n16_ovf", i16.ovf, 0);
    chk("n16_lat", lat, 17);
    tick;

    // Random back-to-back operands against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      rb = 8'($urandom_range(0, 255));
      rm = 2'($urandom_range(0, 3));
      if (i == 0) rb = 8'h80;
      run8(rb, rm, r, o, lat);
      exp9 = model8(rb, rm);
      chk("rand_result", {o, r}, exp9);
      chk("rand_lat", lat, 9);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
